// File: rtl/main_fsm_pkg.sv
// Shared types for the multi-cycle RV32 controller: FSM states, opcodes,
// datapath select encodings and the per-state control decode.
package main_fsm_pkg;

   // Controller states, one per cycle of an instruction
   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BEQ,
      JAL
   } statetype;

   // Opcode field values of the supported instructions
   typedef enum logic [6:0] {
      OP_LW    = 7'b0000011,
      OP_ITYPE = 7'b0010011,
      OP_SW    = 7'b0100011,
      OP_RTYPE = 7'b0110011,
      OP_BEQ   = 7'b1100011,
      OP_JAL   = 7'b1101111
   } opcodetype;

   // ALUOp encodings consumed by the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ResultSrc encodings
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA encodings
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Control bundle produced by each state
   typedef struct packed {
      logic       pcupdate;
      logic       branch;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
   } ctrl_t;

   // States that own the memory port and may have to wait for it
   function automatic logic is_mem_state(statetype s);
      return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
   endfunction

   // Moore decode: control values for a given state; anything not set is 0
   function automatic ctrl_t state_ctrl(statetype s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.irwrite   = 1'b1;
            c.pcupdate  = 1'b1;
            c.alusrca   = SRCA_PC;
            c.alusrcb   = SRCB_FOUR;
            c.aluop     = ALUOP_ADD;
            c.resultsrc = RES_ALURESULT;
         end
         DECODE: begin
            // Branch target computed early so BEQ can use it from ALUOut
            c.alusrca = SRCA_OLDPC;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALUOP_ADD;
         end
         MEMADR: begin
            c.alusrca = SRCA_RD1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALUOP_ADD;
         end
         MEMREAD: begin
            c.resultsrc = RES_ALUOUT;
            c.adrsrc    = 1'b1;
         end
         MEMWB: begin
            c.resultsrc = RES_DATA;
            c.regwrite  = 1'b1;
         end
         MEMWRITE: begin
            c.resultsrc = RES_ALUOUT;
            c.adrsrc    = 1'b1;
            c.memwrite  = 1'b1;
         end
         EXECUTER: begin
            c.alusrca = SRCA_RD1;
            c.alusrcb = SRCB_RD2;
            c.aluop   = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            c.alusrca = SRCA_RD1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            c.resultsrc = RES_ALUOUT;
            c.regwrite  = 1'b1;
         end
         BEQ: begin
            c.alusrca   = SRCA_RD1;
            c.alusrcb   = SRCB_RD2;
            c.aluop     = ALUOP_SUB;
            c.resultsrc = RES_ALUOUT;
            c.branch    = 1'b1;
         end
         JAL: begin
            c.alusrca   = SRCA_OLDPC;
            c.alusrcb   = SRCB_FOUR;
            c.aluop     = ALUOP_ADD;
            c.resultsrc = RES_ALUOUT;
            c.pcupdate  = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/main_fsm.sv
// Moore control FSM for the multi-cycle RV32 core (lw, sw, R-type, I-type,
// beq, jal). Holds the state register, next-state logic, output decode and
// the retired-instruction counter.
// Optional feature: define MAIN_FSM_MEM_WAIT_EN to make FETCH, MEMREAD and
// MEMWRITE wait for mem_ready, with a MEM_TIMEOUT watchdog raising mem_err.
module main_fsm
   import main_fsm_pkg::*;
#(
   parameter int INSTRET_W   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic                 Zero,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ALUOp,
   output logic                 illegal_op,
   output logic                 mem_err,
   output logic [INSTRET_W-1:0] instret
);

   statetype state;
   statetype state_next;
   logic     mem_done;   // memory port finished its access this cycle
   logic     timeout;    // memory watchdog expired this cycle
   logic     illegal;    // DECODE saw an unsupported opcode
   logic     retire;     // an instruction completes on this edge
   ctrl_t    ctrl;

`ifdef MAIN_FSM_MEM_WAIT_EN
   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   logic [WAIT_W-1:0] wait_cnt;

   assign mem_done = mem_ready;
   assign timeout  = is_mem_state(state) && !mem_ready &&
                     (wait_cnt == WAIT_W'(MEM_TIMEOUT));
`else
   logic unused_mem;

   assign mem_done   = 1'b1;
   assign timeout    = 1'b0;
   assign unused_mem = mem_ready ^ (MEM_TIMEOUT == 0);
`endif

   // Next-state selection and the illegal-opcode / retire conditions
   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
      state_next = state;
      illegal    = 1'b0;
      case (state)
         FETCH:    if (mem_done) state_next = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECUTER;
               OP_ITYPE:     state_next = EXECUTEI;
               OP_BEQ:       state_next = BEQ;
               OP_JAL:       state_next = JAL;
               default: begin
                  state_next = FETCH;
                  illegal    = 1'b1;
               end
            endcase
         end
         MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (mem_done) state_next = MEMWB;
         MEMWB:    state_next = FETCH;
         MEMWRITE: if (mem_done) state_next = FETCH;
         EXECUTER: state_next = ALUWB;
         EXECUTEI: state_next = ALUWB;
         ALUWB:    state_next = FETCH;
         BEQ:      state_next = FETCH;
         JAL:      state_next = ALUWB;
         default:  state_next = FETCH;
      endcase
      if (timeout) state_next = FETCH;

      retire = (state_next == FETCH) && !timeout &&
               ((state == MEMWB) || (state == MEMWRITE) ||
                (state == ALUWB) || (state == BEQ));
   end

   // Output decode from the state; write enables drop during reset or timeout
   always_comb begin
      ctrl = state_ctrl(state);
`ifdef MAIN_FSM_MEM_WAIT_EN
      if (state == FETCH && !mem_ready) begin
         ctrl.irwrite  = 1'b0;
         ctrl.pcupdate = 1'b0;
      end
      if (timeout) begin
         ctrl.pcupdate = 1'b0;
         ctrl.branch   = 1'b0;
         ctrl.memwrite = 1'b0;
         ctrl.irwrite  = 1'b0;
         ctrl.regwrite = 1'b0;
      end
`endif
      if (reset) ctrl = '0;

      PCWrite    = ctrl.pcupdate | (ctrl.branch & Zero);
      AdrSrc     = ctrl.adrsrc;
      MemWrite   = ctrl.memwrite;
      IRWrite    = ctrl.irwrite;
      RegWrite   = ctrl.regwrite;
      ResultSrc  = ctrl.resultsrc;
      ALUSrcA    = ctrl.alusrca;
      ALUSrcB    = ctrl.alusrcb;
      ALUOp      = ctrl.aluop;
      illegal_op = illegal & ~reset;
      mem_err    = timeout & ~reset;
   end

   // State register, retired-instruction counter and memory wait counter
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state   <= FETCH;
         instret <= '0;
`ifdef MAIN_FSM_MEM_WAIT_EN
         wait_cnt <= '0;
`endif
      end else begin
         state <= state_next;
         if (retire) instret <= instret + INSTRET_W'(1);
`ifdef MAIN_FSM_MEM_WAIT_EN
         // Restart the wait count whenever a state is (re)entered
         if (timeout || state_next != state) wait_cnt <= '0;
         else if (is_mem_state(state))       wait_cnt <= wait_cnt + WAIT_W'(1);
`endif
      end
   end

endmodule

// File: tb/tb_main_fsm.sv
// Directed testbench for main_fsm. Each cycle the full output bundle is
// compared against hand-written per-state vectors. Built with a 3-bit
// instret so wrap-around is reachable; the memory-wait scenario runs when
// MAIN_FSM_MEM_WAIT_EN is defined (MEM_TIMEOUT = 4).
module tb_main_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic       illegal_op, mem_err;
   logic [2:0] instret;

   int checks   = 0;
   int failures = 0;

   main_fsm #(.INSTRET_W(3), .MEM_TIMEOUT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .Zero      (Zero),
      .mem_ready (mem_ready),
      .PCWrite   (PCWrite),
      .AdrSrc    (AdrSrc),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .illegal_op(illegal_op),
      .mem_err   (mem_err),
      .instret   (instret)
   );

   always #5 clk = ~clk;

   // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op, mem_err}
   logic [14:0] outs;
   assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op, mem_err};

   localparam logic [14:0] E_ZERO     = 15'b0_0_0_0_0_00_00_00_00_0_0;
   localparam logic [14:0] E_FETCH    = 15'b1_0_0_1_0_10_00_10_00_0_0;
   localparam logic [14:0] E_DECODE   = 15'b0_0_0_0_0_00_01_01_00_0_0;
   localparam logic [14:0] E_ILLEGAL  = 15'b0_0_0_0_0_00_01_01_00_1_0;
   localparam logic [14:0] E_MEMADR   = 15'b0_0_0_0_0_00_10_01_00_0_0;
   localparam logic [14:0] E_MEMREAD  = 15'b0_1_0_0_0_00_00_00_00_0_0;
   localparam logic [14:0] E_MEMWB    = 15'b0_0_0_0_1_01_00_00_00_0_0;
   localparam logic [14:0] E_MEMWRITE = 15'b0_1_1_0_0_00_00_00_00_0_0;
   localparam logic [14:0] E_EXECR    = 15'b0_0_0_0_0_00_10_00_10_0_0;
   localparam logic [14:0] E_EXECI    = 15'b0_0_0_0_0_00_10_01_10_0_0;
   localparam logic [14:0] E_ALUWB    = 15'b0_0_0_0_1_00_00_00_00_0_0;
   localparam logic [14:0] E_BEQ_NT   = 15'b0_0_0_0_0_00_10_00_01_0_0;
   localparam logic [14:0] E_BEQ_T    = 15'b1_0_0_0_0_00_10_00_01_0_0;
   localparam logic [14:0] E_JAL      = 15'b1_0_0_0_0_00_01_10_00_0_0;
   localparam logic [14:0] E_FETCH_WT = 15'b0_0_0_0_0_10_00_10_00_0_0;
   localparam logic [14:0] E_MW_TMO   = 15'b0_1_0_0_0_00_00_00_00_0_1;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compare outputs mid-cycle, then advance to just after the next edge
   task automatic cyc(input string tag, input logic [14:0] exp);
      @(negedge clk);
      check(tag, {17'd0, outs}, {17'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ret(input string tag, input int exp);
      check(tag, {29'd0, instret}, exp);
   endtask

   initial begin
      reset     = 1'b1;
      op        = OP_LW;
      Zero      = 1'b0;
      mem_ready = 1'b1;

      // Reset held for two cycles: everything low
      cyc("reset_c0", E_ZERO);
      cyc("reset_c1", E_ZERO);
      reset = 1'b0;
      chk_ret("instret_reset", 0);

      // lw: 5 cycles, RegWrite only in MEMWB
      cyc("lw_fetch", E_FETCH);
      cyc("lw_decode", E_DECODE);
      cyc("lw_memadr", E_MEMADR);
      cyc("lw_memread", E_MEMREAD);
      cyc("lw_memwb", E_MEMWB);
      chk_ret("instret_lw", 1);

      // beq taken then not taken: 3 cycles each
      op = OP_BEQ; Zero = 1'b1;
      cyc("beq_t_fetch", E_FETCH);
      cyc("beq_t_decode", E_DECODE);
      cyc("beq_t_beq", E_BEQ_T);
      chk_ret("instret_beq_t", 2);
      Zero = 1'b0;
      cyc("beq_nt_fetch", E_FETCH);
      cyc("beq_nt_decode", E_DECODE);
      cyc("beq_nt_beq", E_BEQ_NT);
      chk_ret("instret_beq_nt", 3);

      // jal: PCWrite in FETCH and JAL, RegWrite in ALUWB
      op = OP_JAL;
      cyc("jal_fetch", E_FETCH);
      cyc("jal_decode", E_DECODE);
      cyc("jal_jal", E_JAL);
      cyc("jal_aluwb", E_ALUWB);
      chk_ret("instret_jal", 4);

      // R-type and I-type ALU
      op = OP_R;
      cyc("r_fetch", E_FETCH);
      cyc("r_decode", E_DECODE);
      cyc("r_exec", E_EXECR);
      cyc("r_aluwb", E_ALUWB);
      chk_ret("instret_r", 5);
      op = OP_I;
      cyc("i_fetch", E_FETCH);
      cyc("i_decode", E_DECODE);
      cyc("i_exec", E_EXECI);
      cyc("i_aluwb", E_ALUWB);
      chk_ret("instret_i", 6);

      // sw: 4 cycles
      op = OP_SW;
      cyc("sw_fetch", E_FETCH);
      cyc("sw_decode", E_DECODE);
      cyc("sw_memadr", E_MEMADR);
      cyc("sw_memwrite", E_MEMWRITE);
      chk_ret("instret_sw", 7);

      // Unsupported opcode: pulse in DECODE, straight back to FETCH
      op = OP_LUI;
      cyc("ill_fetch", E_FETCH);
      cyc("ill_decode", E_ILLEGAL);
      chk_ret("instret_ill", 7);
      cyc("ill_refetch", E_FETCH);

      // Reset during MEMWRITE aborts the store
      op = OP_SW;
      cyc("abort_decode", E_DECODE);
      cyc("abort_memadr", E_MEMADR);
      reset = 1'b1;
      cyc("abort_memwrite", E_ZERO);
      reset = 1'b0;
      chk_ret("instret_abort", 0);
      cyc("abort_fetch", E_FETCH);

      // Eight beqs: instret counts 1..7 then wraps to 0
      op = OP_BEQ; Zero = 1'b0;
      cyc("wrap_decode0", E_DECODE);
      cyc("wrap_beq0", E_BEQ_NT);
      chk_ret("wrap_ret0", 1);
      for (int i = 1; i < 8; i++) begin
         cyc("wrap_fetch", E_FETCH);
         cyc("wrap_decode", E_DECODE);
         cyc("wrap_beq", E_BEQ_NT);
         chk_ret("wrap_ret", (i + 1) % 8);
      end

`ifdef MAIN_FSM_MEM_WAIT_EN
      // FETCH waits for mem_ready without IRWrite/PCWrite
      op = OP_SW; mem_ready = 1'b0;
      cyc("mw_fetch_hold0", E_FETCH_WT);
      cyc("mw_fetch_hold1", E_FETCH_WT);
      mem_ready = 1'b1;
      cyc("mw_fetch", E_FETCH);
      cyc("mw_decode", E_DECODE);
      cyc("mw_memadr", E_MEMADR);
      // Store never acknowledged: 4 held cycles then mem_err
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) cyc("mw_memwrite_hold", E_MEMWRITE);
      cyc("mw_timeout", E_MW_TMO);
      chk_ret("instret_timeout", 0);
      cyc("mw_after_tmo", E_FETCH_WT);
      // Acknowledged store retires normally
      mem_ready = 1'b1;
      cyc("mw_ok_fetch", E_FETCH);
      cyc("mw_ok_decode", E_DECODE);
      cyc("mw_ok_memadr", E_MEMADR);
      cyc("mw_ok_memwrite", E_MEMWRITE);
      chk_ret("instret_mw_ok", 1);
`else
      // mem_ready is ignored: sw still takes 4 cycles
      op = OP_SW; mem_ready = 1'b0;
      cyc("nr_fetch", E_FETCH);
      cyc("nr_decode", E_DECODE);
      cyc("nr_memadr", E_MEMADR);
      cyc("nr_memwrite", E_MEMWRITE);
      chk_ret("instret_nr", 1);
      cyc("nr_refetch", E_FETCH);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
